// File: rtl/video_timing_gen_pkg.sv
// Shared types and default timing for the video timing generator.
// Holds the FSM state enum, 640x480 default timing and frame-total helpers.
// Imported by the top level and its counter sub-module.
package video_timing_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        STOP_PEND = 2'd2
    } state_t;

    localparam int DEF_IW     = 640;
    localparam int DEF_IH     = 480;
    localparam int DEF_DW     = 8;
    localparam int DEF_H_SYNC = 96;
    localparam int DEF_H_BP   = 48;
    localparam int DEF_H_FP   = 16;
    localparam int DEF_V_SYNC = 2;
    localparam int DEF_V_BP   = 33;
    localparam int DEF_V_FP   = 10;

    // Clocks per line: sync + back porch + active + front porch.
    function automatic int h_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

    // Lines per frame, same ordering as a line.
    function automatic int v_total(input int sync, input int bp, input int act, input int fp);
        return sync + bp + act + fp;
    endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// Video timing output bundle: sync strobes, pixel qualifier/data, frame status.
// Pure wiring, no latency.
// No backpressure: the sink must accept every cycle.
// Optional: frame_cnt exists only when FRAME_CNT_EN is defined.
interface video_timing_gen_if #(
    parameter int DW = 8
) ();
    logic          vsync;
    logic          hsync;
    logic          dvalid;
    logic [DW-1:0] data;
    logic          frame_start;
    logic          busy;
`ifdef FRAME_CNT_EN
    logic [15:0]   frame_cnt;
`endif

    modport master (
        output vsync, hsync, dvalid, data, frame_start, busy
`ifdef FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        input vsync, hsync, dvalid, data, frame_start, busy
`ifdef FRAME_CNT_EN
        , input frame_cnt
`endif
    );
endinterface

// File: rtl/video_timing_gen_wrap_counter.sv
// Modulus-MOD counter with enable, synchronous clear and terminal-count flag.
// Latency: count updates one clock after en; tc is combinational from the count.
// No backpressure; clr has priority over en.
// Ports: clk, arstn, en, clr in; cnt (W bits) and tc out.
module wrap_counter #(
    parameter int MOD = 8,
    parameter int W   = 3
) (
    input  logic         clk,
    input  logic         arstn,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         tc
);
    assign tc = (cnt == W'(MOD - 1));

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + W'(1);
        end
    end
endmodule

// File: rtl/video_timing_gen.sv
// Frame timing source: vsync/hsync/dvalid plus a pixel ramp, clean start/stop on frame edges.
// Latency: every output is registered one clock after the counter state it decodes.
// No backpressure; en is a level run request, a stop always completes the current frame.
// Ports: clk, arstn (async active-low), en in; vid (master) carries vsync, hsync,
// dvalid, data, frame_start, busy. Defining FRAME_CNT_EN adds vid.frame_cnt (16 bits).
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int IW     = DEF_IW,
    parameter int IH     = DEF_IH,
    parameter int DW     = DEF_DW,
    parameter int H_SYNC = DEF_H_SYNC,
    parameter int H_BP   = DEF_H_BP,
    parameter int H_FP   = DEF_H_FP,
    parameter int V_SYNC = DEF_V_SYNC,
    parameter int V_BP   = DEF_V_BP,
    parameter int V_FP   = DEF_V_FP
) (
    input  logic               clk,
    input  logic               arstn,
    input  logic               en,
    video_timing_gen_if.master vid
);
    localparam int H_TOTAL = h_total(H_SYNC, H_BP, IW, H_FP);
    localparam int V_TOTAL = v_total(V_SYNC, V_BP, IH, V_FP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    state_t          state;
    logic            run;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            h_tc;
    logic            v_tc;

    assign run = (state != IDLE);

    // Counters are held at zero in IDLE so the first RUN cycle sits on the first sync cycle.
    wrap_counter #(.MOD(H_TOTAL), .W(HW)) u_h_cnt (
        .clk   (clk),
        .arstn (arstn),
        .en    (run),
        .clr   (!run),
        .cnt   (h_cnt),
        .tc    (h_tc)
    );

    wrap_counter #(.MOD(V_TOTAL), .W(VW)) u_v_cnt (
        .clk   (clk),
        .arstn (arstn),
        .en    (run & h_tc),
        .clr   (!run),
        .cnt   (v_cnt),
        .tc    (v_tc)
    );

    // A stop only takes effect on the last clock of a frame; both counters wrap to
    // zero on that same edge, so IDLE is entered already at the frame origin.
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:      if (en) state <= RUN;
                RUN:       if (!en) state <= STOP_PEND;
                STOP_PEND: begin
                    if (en)               state <= RUN;
                    else if (h_tc && v_tc) state <= IDLE;
                end
                default:   state <= IDLE;
            endcase
        end
    end

    logic          hs, vs, ha, va;
    logic [DW-1:0] px;

    assign hs = (h_cnt < HW'(H_SYNC));
    assign vs = (v_cnt < VW'(V_SYNC));
    assign ha = (h_cnt >= HW'(H_SYNC + H_BP)) && (h_cnt < HW'(H_SYNC + H_BP + IW));
    assign va = (v_cnt >= VW'(V_SYNC + V_BP)) && (v_cnt < VW'(V_SYNC + V_BP + IH));
    // Ramp is x+y within the active window; modular arithmetic lets us truncate first.
    assign px = DW'(h_cnt) - DW'(H_SYNC + H_BP) + DW'(v_cnt) - DW'(V_SYNC + V_BP);

    logic          vsync_q, hsync_q, dvalid_q, fs_q, busy_q;
    logic [DW-1:0] data_q;

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn || !run) begin
            vsync_q  <= 1'b0;
            hsync_q  <= 1'b0;
            dvalid_q <= 1'b0;
            data_q   <= '0;
            fs_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            vsync_q  <= vs;
            hsync_q  <= hs;
            dvalid_q <= ha & va;
            data_q   <= (ha & va) ? px : '0;
            fs_q     <= (h_cnt == '0) && (v_cnt == '0);
            busy_q   <= 1'b1;
        end
    end

    assign vid.vsync       = vsync_q;
    assign vid.hsync       = hsync_q;
    assign vid.dvalid      = dvalid_q;
    assign vid.data        = data_q;
    assign vid.frame_start = fs_q;
    assign vid.busy        = busy_q;

`ifdef FRAME_CNT_EN
    // Advances on the same edge that raises frame_start; kept through IDLE.
    logic [15:0] fcnt_q;
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            fcnt_q <= '0;
        end else if (run && (h_cnt == '0) && (v_cnt == '0)) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end
    assign vid.frame_cnt = fcnt_q;
`endif
endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a 4x2 image and unit porches/syncs (35-cycle frame).
// Reference model tracks a frame position 0..34 and derives every output from it.
// frame_cnt is checked when FRAME_CNT_EN is defined.
module tb_video_timing_gen;
    localparam int IW = 4, IH = 2, DW = 8;
    localparam int HS = 1, HB = 1, HF = 1, VS = 1, VB = 1, VF = 1;
    localparam int HT = HS + HB + IW + HF;
    localparam int VT = VS + VB + IH + VF;
    localparam int FT = HT * VT;

    logic clk = 1'b0;
    logic arstn = 1'b0;
    logic en = 1'b0;

    always #5 clk = ~clk;

    video_timing_gen_if #(.DW(DW)) vid ();

    video_timing_gen #(
        .IW(IW), .IH(IH), .DW(DW),
        .H_SYNC(HS), .H_BP(HB), .H_FP(HF),
        .V_SYNC(VS), .V_BP(VB), .V_FP(VF)
    ) dut (
        .clk   (clk),
        .arstn (arstn),
        .en    (en),
        .vid   (vid)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: frame in progress, position within frame, stop pending.
    bit  m_run  = 0;
    bit  m_stop = 0;
    int  m_pos  = 0;
    int  m_fcnt = 0;
    bit  e_vs, e_hs, e_dv, e_fs, e_busy;
    int  e_data;

    task automatic model_step(input bit e);
        int h, v;
        h = m_pos % HT;
        v = m_pos / HT;
        if (m_run) begin
            e_vs   = (v < VS);
            e_hs   = (h < HS);
            e_dv   = (h >= HS + HB) && (h < HS + HB + IW) && (v >= VS + VB) && (v < VS + VB + IH);
            e_data = e_dv ? ((h - (HS + HB)) + (v - (VS + VB))) % 256 : 0;
            e_fs   = (m_pos == 0);
            e_busy = 1;
        end else begin
            {e_vs, e_hs, e_dv, e_fs, e_busy} = '0;
            e_data = 0;
        end
        if (e_fs) m_fcnt = (m_fcnt + 1) % 65536;
        if (!m_run) begin
            if (e) begin m_run = 1; m_pos = 0; m_stop = 0; end
        end else if (m_stop && !e && m_pos == FT - 1) begin
            m_run = 0; m_pos = 0; m_stop = 0;
        end else begin
            m_stop = !e;
            m_pos  = (m_pos + 1) % FT;
        end
    endtask

    task automatic check_outputs();
        chk("vsync",       32'(vid.vsync),       32'(e_vs));
        chk("hsync",       32'(vid.hsync),       32'(e_hs));
        chk("dvalid",      32'(vid.dvalid),      32'(e_dv));
        chk("data",        32'(vid.data),        32'(e_data));
        chk("frame_start", 32'(vid.frame_start), 32'(e_fs));
        chk("busy",        32'(vid.busy),        32'(e_busy));
        chk("dv_vs_hs_excl", 32'(vid.dvalid & (vid.vsync | vid.hsync)), 32'd0);
`ifdef FRAME_CNT_EN
        chk("frame_cnt",   32'(vid.frame_cnt),   32'(m_fcnt));
`endif
    endtask

    int c_fs, c_dv, c_vs, c_hs;

    task automatic tick(input bit e);
        en = e;
        model_step(e);
        @(negedge clk);
        check_outputs();
        c_fs += int'(vid.frame_start);
        c_dv += int'(vid.dvalid);
        c_vs += int'(vid.vsync);
        c_hs += int'(vid.hsync);
    endtask

    task automatic async_reset();
        #2 arstn = 1'b0;
        #1;
        chk("rst_vsync",  32'(vid.vsync),       32'd0);
        chk("rst_hsync",  32'(vid.hsync),       32'd0);
        chk("rst_dvalid", 32'(vid.dvalid),      32'd0);
        chk("rst_data",   32'(vid.data),        32'd0);
        chk("rst_fs",     32'(vid.frame_start), 32'd0);
        chk("rst_busy",   32'(vid.busy),        32'd0);
        m_run = 0; m_pos = 0; m_stop = 0; m_fcnt = 0;
        {e_vs, e_hs, e_dv, e_fs, e_busy} = '0;
        e_data = 0;
        @(negedge clk);
        arstn = 1'b1;
    endtask

    initial begin
        int n;
        // Reset state
        @(negedge clk);
        @(negedge clk);
        async_reset();
        {e_vs, e_hs, e_dv, e_fs, e_busy} = '0;
        e_data = 0;

        // Three back-to-back frames with en held high
        c_fs = 0; c_dv = 0; c_vs = 0; c_hs = 0;
        for (int i = 0; i < 2 + 3 * FT - 1; i++) tick(1'b1);
        chk("cnt_frame_start", 32'(c_fs), 32'd3);
        chk("cnt_dvalid",      32'(c_dv), 32'(3 * IW * IH));
        chk("cnt_vsync",       32'(c_vs), 32'(3 * VS * HT));
        chk("cnt_hsync",       32'(c_hs), 32'(3 * VT * HS));

        // Drop en mid-frame: frame completes, then idle
        for (int i = 0; i < 10; i++) tick(1'b1);
        for (int i = 0; i < 2 * FT; i++) tick(1'b0);
        chk("idle_busy", 32'(vid.busy), 32'd0);

        // Drop and re-raise inside one frame: no timing disturbance
        for (int i = 0; i < 40; i++) tick(1'b1);
        for (int i = 0; i < 5; i++) tick(1'b0);
        for (int i = 0; i < 2 * FT; i++) tick(1'b1);

        // Async reset in the middle of the active region, then restart
        n = 0;
        while (!(m_run && m_pos == 2 * HT + 3) && n < 2 * FT) begin
            tick(1'b1);
            n++;
        end
        chk("reach_active", 32'(m_pos), 32'(2 * HT + 3));
        async_reset();
        for (int i = 0; i < FT + 10; i++) tick(1'b1);

        // Randomised run requests with occasional resets
        for (int s = 0; s < 40; s++) begin
            bit e;
            int len;
            e   = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 60);
            for (int i = 0; i < len; i++) tick(e);
            if ($urandom_range(0, 9) == 0) async_reset();
        end

        // Final stop: must settle to idle with all outputs low
        for (int i = 0; i < 3 * FT; i++) tick(1'b0);
        chk("final_busy",   32'(vid.busy),   32'd0);
        chk("final_dvalid", 32'(vid.dvalid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Frame timing source that sits directly upstream of the image line/column counter stage. Generates vsync, hsync and dvalid with programmable sync, back-porch and front-porch intervals, plus a deterministic pixel ramp on data. Start and stop are clean: the block always begins a frame at its first sync cycle and always ends on a frame boundary. All strobes are active-high; vsync spans whole lines, which matches the downstream counter-reset convention.

Parameters:
IW, 640, active pixels per line
IH, 480, active lines per frame
DW, 8, pixel data width
H_SYNC, 96, hsync width in clocks (>=1)
H_BP, 48, horizontal back porch in clocks (>=1)
H_FP, 16, horizontal front porch in clocks (>=1)
V_SYNC, 2, vsync width in lines (>=1)
V_BP, 33, vertical back porch in lines (>=1)
V_FP, 10, vertical front porch in lines (>=1)

Ports:
clk  in  1  pixel clock
arstn  in  1  asynchronous active-low reset
en  in  1  run request, level-sensitive
vsync  out  1  frame sync, active-high
hsync  out  1  line sync, active-high
dvalid  out  1  active-pixel qualifier
data  out  DW  pixel value, 0 outside active
frame_start  out  1  one-cycle pulse on the first vsync cycle of each frame
busy  out  1  high while a frame is in progress

Behaviour:
- Clocking and reset: single clock clk. Reset arstn is asynchronous, active-low.
- Timing totals: H_TOTAL = H_SYNC+H_BP+IW+H_FP. V_TOTAL = V_SYNC+V_BP+IH+V_FP.
- Counter widths: h_cnt is $clog2(H_TOTAL) bits. v_cnt is $clog2(V_TOTAL) bits. Both are unsigned.
- Line order: sync, back porch, active, front porch. Frame order is the same.
- Reset: state IDLE; h_cnt=v_cnt=0; all outputs 0. Reset mid-frame aborts immediately, with no partial-frame completion.
- FSM states: IDLE, RUN, STOP_PEND.
  - IDLE: counters held at 0, outputs 0. en=1 sampled at an edge moves to RUN; the counters are 0 in the first RUN cycle.
  - RUN: h_cnt increments every cycle and wraps H_TOTAL-1 -> 0. On that wrap, v_cnt increments and wraps V_TOTAL-1 -> 0. en=0 moves to STOP_PEND.
  - STOP_PEND: counts as RUN. en=1 returns to RUN with no timing disturbance. At h_cnt=H_TOTAL-1 and v_cnt=V_TOTAL-1, it moves to IDLE and the counters return to 0.
- Decodes, computed from the current counters:
  - hs = h_cnt < H_SYNC
  - vs = v_cnt < V_SYNC
  - ha = H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+IW
  - va = V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+IH
- Registered outputs: all outputs are registered with latency 1 from the counter state. In IDLE, all outputs are forced to 0.
  - vsync = vs
  - hsync = hs
  - dvalid = ha & va
  - frame_start = (h_cnt==0 & v_cnt==0 & state!=IDLE)
  - busy = state!=IDLE
- Data: x = h_cnt-(H_SYNC+H_BP) and y = v_cnt-(V_SYNC+V_BP). data = (x+y) modulo 2^DW when dvalid, otherwise 0.
- Guaranteed properties:
  - Each frame contains exactly IH dvalid bursts of exactly IW cycles.
  - dvalid is never high while vsync or hsync is high.
  - Back-to-back frames have no gap cycle.

Optional Feature:
FRAME_CNT_EN
- Defined: adds output frame_cnt (16 bits), reset 0.
  - Increments, registered, in the same cycle frame_start is high; the first frame after reset reads 1.
  - Wraps 0xFFFF -> 0. Held, not cleared, through IDLE.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Shared package (video_timing_pkg):
  - FSM state enum.
  - Default timing constants for 640x480.
  - Functions computing H_TOTAL and V_TOTAL.
- Sub-module: wrap_counter, a parameterised modulus counter with enable, synchronous clear and a terminal-count flag. It is instantiated twice: horizontal, and vertical enabled by the horizontal terminal count.
- Decode, FSM and output registers stay in the top level.

Test Plan:
Bench settings: IW=4, IH=2, all porch and sync parameters =1. This gives H_TOTAL=7, V_TOTAL=5, a 35-cycle frame.
- Reset then en=1 held -> frame_start every 35 cycles. vsync high 7 cycles per frame. hsync high 1 of every 7 cycles. 8 dvalid cycles per frame in 2 bursts of 4.
- First frame -> first dvalid 16 cycles after frame_start. data sequence 0,1,2,3, then 1,2,3,4.
- en dropped mid-frame -> frame completes, busy falls right after the cycle carrying v_cnt=4 and h_cnt=6, outputs then stay 0.
- en dropped and re-raised within the same frame -> no gap; next frame_start still exactly 35 cycles after the previous one.
- arstn pulsed low mid-active -> all outputs 0 immediately. Restart with en=1 yields a full frame from vsync.
- FRAME_CNT_EN defined, 3 frames run -> frame_cnt = 1, 2, 3, incrementing with frame_start. Value held after stop.
